spi_ctrl_writer: RTL
====================

# spi_ctrl_writer

SPI controller (initiator) that issues 16-bit register transactions to the chip's SPI peripheral register bank. It is the other end of the onboarding SPI link: a host-side or test-harness block drives a start pulse with address and data, and this block produces nCS/SCLK/COPI in SPI mode 0, MSB first. It also captures CIPO for read-back. It sits between bench or host logic and the pins routed to the peripheral's ui_in inputs.

## Interface
Parameters:
- CLK_DIV, default 4: SCLK half-period in clk cycles (H). Legal range 1..255.

Ports:
- clk  input  1  system clock; one clock domain
- rst  input  1  reset, asynchronous, active-high
- start  input  1  single-cycle request; sampled only while busy=0
- rw  input  1  frame bit 15: 1 = write, 0 = read
- addr  input  7  register address, frame bits 14:8
- wdata  input  8  write data, frame bits 7:0; still shifted out on reads
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse at transaction end
- rdata  output  8  last 8 bits sampled from CIPO; valid from the done cycle
- ncs  output  1  chip select, active low
- sclk  output  1  serial clock, idles low
- copi  output  1  controller-out data
- cipo  input  1  controller-in data, already synchronous to clk

## Operation
- Frame = {rw, addr[6:0], wdata[7:0]}, 16 bits, MSB first. Mode 0: COPI changes on SCLK falling edges, both sides sample on rising edges.
- States:
  - IDLE: ncs=1, sclk=0, copi=0, busy=0. start=1 latches the frame into tx_shift, clears rx_shift and goes to SHIFT.
  - SHIFT: ncs=0, copi=tx_shift[15]. Half-period counter toggles sclk every H cycles.
    - On each rising edge: rx_shift <= {rx_shift[14:0], cipo}.
    - On each falling edge except the last: tx_shift shifts left.
    - After 16 rising and 16 falling edges, go to HOLD.
  - HOLD: ncs=0, sclk=0 for H cycles, then go to GAP.
  - GAP: ncs=1, busy=1 for H cycles. Then done=1, rdata <= rx_shift[7:0], busy=0, and return to IDLE in the same cycle.
- start while busy=1 is ignored; it is not queued.
- start in the done cycle is accepted, since busy=0 in that cycle.
- Frame inputs matter only in the cycle start is accepted. Later changes have no effect.
- rdata holds its value until the next done. It is updated on writes as well.
- Bit and half-period counters are sized for CLK_DIV up to 255 and a 32-edge count. No counter wraps within a legal transaction.

## Timing
- Reset (asynchronous, on assertion) forces the following, regardless of state:
  - ncs=1, sclk=0, copi=0, busy=0, done=0, rdata=0x00
  - state=IDLE, shift registers cleared
- Reset applied mid-frame therefore raises ncs immediately, without completing the frame and without a done pulse.
- Deassertion of rst is synchronous in effect: the first start is accepted on the first clk edge with rst=0.
- Let start be sampled high at edge 0. Then, in clk cycles after that edge:
  - Cycle 1: ncs=0, busy=1, copi=frame[15].
  - Cycle 1+H: first sclk rise.
  - Cycle 1+(2k+1)H: rise number k+1, for k=0..15. The 16th rise is at 1+31H.
  - Cycle 1+2kH: sclk falls for k=1..16, and copi presents frame[15-k] for k<16. The last fall is at 1+32H.
  - Cycle 1+33H: ncs=1.
  - Cycle 1+34H: done=1, busy=0, rdata valid.
- Latency from start to done is 1+34H cycles: 69 for H=2, 35 for H=1.
- COPI setup before each rising edge is H cycles. The ncs-high gap between back-to-back frames is at least H+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert rst mid-frame at cycle 20 with H=2. Check ncs=1, sclk=0, busy=0 and rdata=0x00 before the next clk edge, and no done pulse.
- Write: H=2, rw=1, addr=0x00, wdata=0xA5. Check the COPI bits sampled on sclk rises are 0x80A5. Check 16 rises, ncs low from cycle 1 to 66, and done at cycle 69.
- Read: H=4, rw=0, addr=0x03. The model drives CIPO 0x005C in mode 0. Check rdata=0x5C at done (cycle 137) and that rdata holds afterwards.
- Ignored start: pulse start at cycles 10 and 40 during an H=2 frame. Check exactly one frame and one done.
- Back-to-back: assert start in the done cycle with new frame 0x8FFF. Check the second frame starts the next cycle, ncs stays high for at least H+1 cycles between frames, and both frames are correct.
- Edge divider: H=1, frame 0xFFFF then 0x0000. Check sclk toggles every cycle, done at cycle 35, and COPI is stable at every rising edge.

Source files
------------

// File: rtl/spi_ctrl_writer.sv
// SPI mode-0 controller: shifts a 16-bit {rw, addr, wdata} frame out MSB first
// and captures the last 8 CIPO bits as rdata. All outputs are registered.
module spi_ctrl_writer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ncs,
    output logic       sclk,
    output logic       copi,
    input  logic       cipo
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  edge_q, edge_d;
    logic [15:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        sclk_q, sclk_d;
    logic        ncs_q, ncs_d;
    logic        copi_q, copi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        half_end;

    assign half_end = (cnt_q == HALF_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        sclk_d  = sclk_q;
        ncs_d   = ncs_q;
        copi_d  = copi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                edge_d = '0;
                if (start) begin
                    tx_d    = {rw, addr, wdata};
                    rx_d    = '0;
                    state_d = SHIFT;
                    ncs_d   = 1'b0;
                    busy_d  = 1'b1;
                    copi_d  = rw;
                end
            end
            SHIFT: begin
                if (half_end) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 6'd1;
                    if (!sclk_q) begin
                        rx_d = {rx_q[6:0], cipo};
                    end else if (edge_q == 6'd31) begin
                        // last fall: frame[0] stays on COPI through HOLD
                        state_d = HOLD;
                    end else begin
                        tx_d = {tx_q[14:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                copi_d = tx_d[15];
            end
            HOLD: begin
                if (half_end) begin
                    cnt_d   = '0;
                    state_d = GAP;
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (half_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = rx_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            sclk_q  <= 1'b0;
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            sclk_q  <= sclk_d;
            ncs_q   <= ncs_d;
            copi_q  <= copi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign ncs   = ncs_q;
    assign sclk  = sclk_q;
    assign copi  = copi_q;

endmodule
